alu_acc_sequencer: RTL and testbench

- Command sequencer for the 8-bit add/subtract ALU (inputs A, B, S, E; output W).
- Accepts opcode+operand commands over a valid/ready handshake into a small FIFO.
- Issues each command to the ALU with the running accumulator as operand A, then writes W back into the accumulator.
- Reports completion, carry/borrow and queue occupancy; sits between a host/test controller and the ALU instance.

---
 rtl/alu_acc_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_alu_acc_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_acc_sequencer.sv
// alu_acc_sequencer: queues CLR/LOAD/ADD/SUB commands in a small FIFO and issues
// them one at a time to an external 8-bit add/subtract ALU. The running
// accumulator is ALU operand A, and the ALU result is written back to it.
// Optional build macro: ACC_SAT_EN. When it is defined, an ADD carry or a SUB
// borrow saturates the accumulator instead of letting it wrap.

module alu_acc_sequencer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [7:0]    cmd_data,
    output logic [7:0]    alu_A,
    output logic [7:0]    alu_B,
    output logic          alu_S,
    output logic          alu_E,
    input  logic [7:0]    alu_W,
    output logic [7:0]    acc,
    output logic          carry,
    output logic          done,
    output logic          busy,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_CLR  = 2'b00,
        OP_LOAD = 2'b01,
        OP_ADD  = 2'b10,
        OP_SUB  = 2'b11
    } op_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Command FIFO entries: {opcode, operand}
    logic [9:0]    fifo_mem [DEPTH];
    logic [9:0]    head;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    state_t        state_q,  state_d;
    op_t           op_q,     op_d;
    logic [7:0]    data_q,   data_d;
    logic [7:0]    acc_q,    acc_d;
    logic          carry_q,  carry_d;

    logic          push;
    logic          pop;
    logic          add_carry;
    logic          sub_borrow;

    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    // The head leaves the queue exactly when the FSM departs IDLE.
    assign pop       = (state_q == ST_IDLE) && (count_q != '0);
    assign head      = fifo_mem[rd_ptr_q];

    assign add_carry  = (9'(acc_q) + 9'(data_q)) > 9'd255;
    assign sub_borrow = data_q > acc_q;

    assign acc   = acc_q;
    assign carry = carry_q;
    assign count = count_q;
    assign busy  = (state_q != ST_IDLE) || (count_q != '0);

    // FIFO pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; an entry is only read after it has been written.
        if (push) fifo_mem[wr_ptr_q] <= {cmd_op, cmd_data};
    end

    // Next state, ALU drive, accumulator write-back and done pulse.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        alu_E   = 1'b0;
        alu_S   = 1'b0;
        alu_A   = 8'h00;
        alu_B   = 8'h00;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    op_d    = op_t'(head[9:8]);
                    data_d  = head[7:0];
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                case (op_q)
                    OP_CLR: begin
                        // ALU disabled, so alu_W is zero and clears the accumulator.
                        carry_d = 1'b0;
                    end
                    OP_LOAD: begin
                        alu_E   = 1'b1;
                        alu_B   = data_q;
                        carry_d = 1'b0;
                    end
                    OP_ADD: begin
                        alu_E   = 1'b1;
                        alu_A   = acc_q;
                        alu_B   = data_q;
                        carry_d = add_carry;
                    end
                    OP_SUB: begin
                        alu_E   = 1'b1;
                        alu_S   = 1'b1;
                        alu_A   = acc_q;
                        alu_B   = data_q;
                        carry_d = sub_borrow;
                    end
                endcase
                // Always take the ALU result, so a faulty ALU shows up on acc.
                acc_d = alu_W;
`ifdef ACC_SAT_EN
                if (op_q == OP_ADD && add_carry)  acc_d = 8'hFF;
                if (op_q == OP_SUB && sub_borrow) acc_d = 8'h00;
`endif
                state_d = ST_DONE;
            end

            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset; a reset also aborts any command in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_CLR;
            data_q   <= 8'h00;
            acc_q    <= 8'h00;
            carry_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Bench for alu_acc_sequencer. It models the external ALU, and it keeps a
// command-level scoreboard that predicts acc, carry and the ALU drive for every
// completed command. It runs the directed scenarios and then a randomized stream.
// Build with +define+ACC_SAT_EN to check the saturating variant.

`timescale 1ns/1ps

module tb_alu_acc_sequencer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam logic [1:0] C_CLR  = 2'b00;
    localparam logic [1:0] C_LOAD = 2'b01;
    localparam logic [1:0] C_ADD  = 2'b10;
    localparam logic [1:0] C_SUB  = 2'b11;

    typedef struct packed {
        logic [1:0] op;
        logic [7:0] data;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [7:0]    cmd_data;
    logic [7:0]    alu_A;
    logic [7:0]    alu_B;
    logic          alu_S;
    logic          alu_E;
    logic [7:0]    alu_W;
    logic [7:0]    acc;
    logic          carry;
    logic          done;
    logic          busy;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    // Behavioural ALU: W = A+B or A-B when enabled, else 0.
    always_comb begin
        alu_W = 8'h00;
        if (alu_E) alu_W = alu_S ? 8'(alu_A - alu_B) : 8'(alu_A + alu_B);
    end

    alu_acc_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_S     (alu_S),
        .alu_E     (alu_E),
        .alu_W     (alu_W),
        .acc       (acc),
        .carry     (carry),
        .done      (done),
        .busy      (busy),
        .count     (count)
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard state
    cmd_t       exp_q[$];
    logic [7:0] model_acc   = 8'h00;
    logic       model_carry = 1'b0;
    int         done_cnt    = 0;
    int         cyc         = 0;
    int         last_done_cyc = -1;
    int         min_gap     = 1000;
    int         max_gap     = 0;
    bit         saw_full    = 1'b0;
    logic       prev_E, prev_S;
    logic [7:0] prev_A, prev_B;
    logic       last_E, last_S;
    logic [7:0] last_A, last_B;

    // Monitor on the falling edge: retire completed commands against the model, then record pushes.
    always @(negedge clk) begin : monitor
        cmd_t       c;
        int         total;
        int         gap;
        logic [7:0] e_acc, e_a, e_b;
        logic       e_carry, e_e, e_s;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("done_unexpected", 32'd1, 32'd0);
            end else begin
                c = exp_q.pop_front();
                e_a = 8'h00; e_b = 8'h00; e_e = 1'b0; e_s = 1'b0;
                e_carry = 1'b0; e_acc = 8'h00;
                case (c.op)
                    C_LOAD: begin
                        e_e = 1'b1; e_b = c.data; e_acc = c.data;
                    end
                    C_ADD: begin
                        total   = int'(model_acc) + int'(c.data);
                        e_e     = 1'b1; e_a = model_acc; e_b = c.data;
                        e_carry = (total > 255);
                        e_acc   = (SAT && e_carry) ? 8'hFF : 8'(total);
                    end
                    C_SUB: begin
                        total   = int'(model_acc) - int'(c.data);
                        e_e     = 1'b1; e_s = 1'b1; e_a = model_acc; e_b = c.data;
                        e_carry = (c.data > model_acc);
                        e_acc   = (SAT && e_carry) ? 8'h00 : 8'(total);
                    end
                    default: ;
                endcase
                check("sb_acc",     32'(acc),    32'(e_acc));
                check("sb_carry",   32'(carry),  32'(e_carry));
                check("sb_issue_E", 32'(prev_E), 32'(e_e));
                check("sb_issue_S", 32'(prev_S), 32'(e_s));
                check("sb_issue_A", 32'(prev_A), 32'(e_a));
                check("sb_issue_B", 32'(prev_B), 32'(e_b));
                model_acc   = e_acc;
                model_carry = e_carry;
                last_E = prev_E; last_S = prev_S; last_A = prev_A; last_B = prev_B;
                if (last_done_cyc >= 0) begin
                    gap = cyc - last_done_cyc;
                    if (gap < min_gap) min_gap = gap;
                    if (gap > max_gap) max_gap = gap;
                    check("done_gap_ge3", 32'(gap >= 3), 32'd1);
                end
                last_done_cyc = cyc;
            end
        end
        if (count == (AW+1)'(DEPTH)) saw_full = 1'b1;
        check("ready_vs_count", 32'(cmd_ready), 32'(count != (AW+1)'(DEPTH)));
        if (rst) begin
            exp_q.delete();
            model_acc     = 8'h00;
            model_carry   = 1'b0;
            last_done_cyc = -1;
        end else if (cmd_valid && cmd_ready) begin
            exp_q.push_back('{op: cmd_op, data: cmd_data});
        end
        prev_E = alu_E; prev_S = alu_S; prev_A = alu_A; prev_B = alu_B;
    end

    // Offer one command and hold it until accepted; call and return at posedge+1.
    task automatic send(input logic [1:0] op, input logic [7:0] d);
        int  guard = 0;
        bit  accepted;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        do begin
            @(negedge clk);
            accepted = cmd_ready;
            @(posedge clk); #1;
            guard++;
        end while (!accepted && guard < 50);
        cmd_valid = 1'b0;
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
    endtask

    // Wait (bounded) until the sequencer is idle with an empty queue.
    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 200);
        check("idle_timeout", 32'(n < 200), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stimulus
        int d0;
        int guard;
        logic [1:0] op;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_acc",   32'(acc),       32'h00);
        check("rst_carry", 32'(carry),     32'd0);
        check("rst_count", 32'(count),     32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_alu_E", 32'(alu_E),     32'd0);
        check("rst_alu_A", 32'(alu_A),     32'h00);
        check("rst_alu_B", 32'(alu_B),     32'h00);
        check("rst_alu_S", 32'(alu_S),     32'd0);
        @(posedge clk); #1;

        // LOAD 0x10, ADD 0x05
        d0 = done_cnt;
        send(C_LOAD, 8'h10);
        send(C_ADD,  8'h05);
        wait_idle();
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd2);
        check("t1_acc",     32'(acc),    32'h15);
        check("t1_carry",   32'(carry),  32'd0);
        check("t1_issue_E", 32'(last_E), 32'd1);
        check("t1_issue_S", 32'(last_S), 32'd0);
        check("t1_issue_A", 32'(last_A), 32'h10);
        check("t1_issue_B", 32'(last_B), 32'h05);

        // ADD overflow
        send(C_LOAD, 8'hF0);
        send(C_ADD,  8'h20);
        wait_idle();
        check("t2_carry", 32'(carry), 32'd1);
        check("t2_acc",   32'(acc),   SAT ? 32'hFF : 32'h10);

        // SUB underflow, then CLR
        send(C_LOAD, 8'h03);
        send(C_SUB,  8'h05);
        wait_idle();
        check("t3_borrow",  32'(carry),  32'd1);
        check("t3_acc",     32'(acc),    SAT ? 32'h00 : 32'hFE);
        check("t3_issue_S", 32'(last_S), 32'd1);
        send(C_CLR, 8'h5A);
        wait_idle();
        check("t3_clr_acc",   32'(acc),    32'h00);
        check("t3_clr_carry", 32'(carry),  32'd0);
        check("t3_clr_E",     32'(last_E), 32'd0);

        // Back-to-back stream filling the FIFO, then a held push while full
        min_gap = 1000; max_gap = 0; saw_full = 1'b0; last_done_cyc = -1;
        for (int i = 0; i < DEPTH + 2; i++) begin
            op = (i == 0) ? C_LOAD : 2'($urandom_range(1, 3));
            send(op, 8'($urandom_range(0, 255)));
        end
        @(negedge clk);
        check("t4_full_count", 32'(count),     32'(DEPTH));
        check("t4_full_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_op    = C_ADD;
        cmd_data  = 8'h07;
        guard     = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (cmd_ready !== 1'b1 && guard < 20);
        check("t4_pop_while_full_count", 32'(count), 32'(DEPTH - 1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_idle();
        check("t4_min_gap",   32'(min_gap),  32'd3);
        check("t4_max_gap",   32'(max_gap),  32'd3);
        check("t4_saw_full",  32'(saw_full), 32'd1);
        check("t4_final_acc", 32'(acc),      32'(model_acc));

        // Push in the same cycle the FSM pops the single queued entry
        send(C_LOAD, 8'h07);
        send(C_ADD,  8'h01);
        @(negedge clk);
        check("t5_push_pop_count", 32'(count), 32'd1);
        @(posedge clk); #1;
        wait_idle();
        check("t5_acc", 32'(acc), 32'h08);

        // Reset during ISSUE of an ADD with two commands queued
        send(C_LOAD, 8'h11);
        send(C_ADD,  8'h22);
        send(C_LOAD, 8'h33);
        send(C_LOAD, 8'h44);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_pre_count", 32'(count), 32'd2);
        check("t6_pre_E",     32'(alu_E), 32'd1);
        check("t6_pre_A",     32'(alu_A), 32'h11);
        check("t6_pre_B",     32'(alu_B), 32'h22);
        #1 rst = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        check("t6_rst_acc",   32'(acc),   32'h00);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_busy",  32'(busy),  32'd0);
        check("t6_rst_done",  32'(done),  32'd0);
        #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        check("t6_no_done",   32'(done_cnt - d0), 32'd0);
        check("t6_idle_acc",  32'(acc),   32'h00);
        check("t6_idle_busy", 32'(busy),  32'd0);
        @(posedge clk); #1;

        // Randomized stream with random idle gaps
        for (int i = 0; i < 150; i++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 4)) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        check("rnd_final_acc",   32'(acc),   32'(model_acc));
        check("rnd_final_carry", 32'(carry), 32'(model_carry));
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
